ifmap_spad_rx: RTL and testbench

PE-side receiver for the diagonal ifmap broadcast: captures the 16-bit ifmap words that the ifmap bank streams onto one diagonal wire and writes them into the PE's ifmap scratchpad in (s, q) order. It sits inside each PE between the diagonal input wire and the MAC datapath. It presents a filled window to the MAC through a registered read port. The bank can be double-buffered so the next sliding-window position loads while the MAC consumes the current one.

---
 rtl/ifmap_spad_rx_pkg.sv | 15 +
 rtl/ifmap_spad_rx_bank.sv | 39 +++
 rtl/ifmap_spad_rx.sv | 173 +++++++++++++++++
 tb/tb_ifmap_spad_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_spad_rx_pkg.sv
// Shared constants and types for the PE-side ifmap scratchpad receiver.
package ifmap_spad_rx_pkg;

    localparam int unsigned DATA_W = 16;   // ifmap word width
    localparam int unsigned DEPTH  = 64;   // entries per spad bank
    localparam int unsigned ADDR_W = 6;    // log2(DEPTH)
    localparam int unsigned CNT_W  = 10;   // width of the q*S word count

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } bank_state_e;

endpackage

// File: rtl/ifmap_spad_rx_bank.sv
// ifmap_spad_bank: one DEPTH x DATA_W scratchpad bank.
// Synchronous write, registered read (rdata updates only when re is high).
// Ports:
//   clk, rst_n      clock, async active-low reset (clears the read register only)
//   we/waddr/wdata  write port
//   re/raddr        read strobe and index
//   rdata           registered read data
module ifmap_spad_bank
    import ifmap_spad_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: no reset, contents undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ifmap_spad_rx.sv
// ifmap_spad_rx: captures the diagonal ifmap broadcast into the PE ifmap
// scratchpad in (s, q) order and presents a filled window to the MAC.
// Build option: define IFMAP_SPAD_RX_DBUF_EN for two banks (window n+1 loads
// while window n is read); otherwise a single bank is used.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    load pass active; low aborts a partial fill
//   q, S                  channels per PE, filter columns (N = q*S words)
//   ld_vld, din           incoming diagonal word
//   rd_en, rd_addr        MAC read strobe and index (s*q + qi)
//   rd_release            MAC done with the current read bank
//   rd_data               registered read data
//   ready                 a full bank is readable
//   busy                  write bank partially filled
//   ovf                   sticky: word arrived with no free bank
//   cfg_err               combinational: q*S == 0 or q*S > DEPTH
module ifmap_spad_rx
    import ifmap_spad_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [4:0]        q,
    input  logic [4:0]        S,
    input  logic              ld_vld,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy,
    output logic              ovf,
    output logic              cfg_err
);

`ifdef IFMAP_SPAD_RX_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic [CNT_W-1:0]  n_words;
    bank_state_e       st_q [2];
    bank_state_e       st_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              ready_d, busy_d, ovf_d;
    logic              wr_open, wr_req, wr_fire, wr_last;
    logic              rd_hit;
    logic              rd_sel_q, rd_zero_q;
    logic [DATA_W-1:0] rdata0, rdata1;

    // Window size and configuration check.
    assign n_words = CNT_W'(q) * CNT_W'(S);
    assign cfg_err = (n_words == '0) || (n_words > CNT_W'(DEPTH));

    // Write acceptance.
    assign wr_req  = en && ld_vld && !cfg_err;
    assign wr_open = (st_q[wr_bank_q] != FULL);
    assign wr_fire = wr_req && wr_open;
    assign wr_last = (CNT_W'(wr_ptr_q) == (n_words - CNT_W'(1)));

    // Reads only touch memory for in-range addresses of a full bank.
    assign rd_hit = rd_en && ready && (CNT_W'(rd_addr) < n_words);

    // Bank FSMs, pointers and status next-state.
    always_comb begin
        st_d      = st_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        ovf_d     = ovf;

        if (wr_req && !wr_open) begin
            ovf_d = 1'b1;
        end

        if (!en) begin
            if (st_q[wr_bank_q] == FILL) begin
                st_d[wr_bank_q] = EMPTY;
            end
            wr_ptr_d = '0;
        end else if (wr_fire) begin
            if (wr_last) begin
                st_d[wr_bank_q] = FULL;
                wr_ptr_d        = '0;
                if (DBUF) begin
                    wr_bank_d = ~wr_bank_q;
                end
            end else begin
                st_d[wr_bank_q] = FILL;
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
            end
        end

        // Release is ignored unless the read bank is full.
        if (rd_release && ready) begin
            st_d[rd_bank_q] = EMPTY;
        end

        // Follow the full bank: covers release-with-other-full and a bank
        // completing after the read bank has already been released.
        if (DBUF && (st_d[rd_bank_q] != FULL) && (st_d[~rd_bank_q] == FULL)) begin
            rd_bank_d = ~rd_bank_q;
        end

        ready_d = (st_d[rd_bank_d] == FULL);
        busy_d  = (st_d[wr_bank_d] == FILL);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= '{EMPTY, EMPTY};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            ready     <= ready_d;
            busy      <= busy_d;
            ovf       <= ovf_d;
        end
    end

    // Read-side select and zero flag, captured alongside the bank read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q  <= 1'b0;
            rd_zero_q <= 1'b1;
        end else if (rd_en) begin
            rd_sel_q  <= rd_bank_q;
            rd_zero_q <= !rd_hit;
        end
    end

    assign rd_data = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);

    ifmap_spad_bank u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && !wr_bank_q),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_hit && !rd_bank_q),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

`ifdef IFMAP_SPAD_RX_DBUF_EN
    ifmap_spad_bank u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && wr_bank_q),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_hit && rd_bank_q),
        .raddr (rd_addr),
        .rdata (rdata1)
    );
`else
    assign rdata1 = '0;
`endif

endmodule

// File: tb/tb_ifmap_spad_rx.sv
// Directed testbench for ifmap_spad_rx (single- or double-buffered build,
// selected by IFMAP_SPAD_RX_DBUF_EN).
module tb_ifmap_spad_rx;
    import ifmap_spad_rx_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [4:0]        q;
    logic [4:0]        S;
    logic              ld_vld;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_release;
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic              busy;
    logic              ovf;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifmap_spad_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .q          (q),
        .S          (S),
        .ld_vld     (ld_vld),
        .din        (din),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_release (rd_release),
        .rd_data    (rd_data),
        .ready      (ready),
        .busy       (busy),
        .ovf        (ovf),
        .cfg_err    (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            ld_vld = 1'b1;
            din    = base + DATA_W'(i);
            tick();
        end
        ld_vld = 1'b0;
    endtask

    task automatic rd(input int addr);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; q = 5'd2; S = 5'd3; ld_vld = 1'b0; din = '0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        tick(); tick();
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_read();
        load(5, 16'h0010);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fill5_ready got %b exp 0", ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill5_busy got %b exp 1", busy); end
        load(1, 16'h0015);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fill6_ready got %b exp 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill6_busy got %b exp 0", busy); end
        for (int i = 0; i < 6; i++) begin
            rd(i);
            checks++;
            if (rd_data !== 16'h0010 + 16'(i)) begin
                errors++; $display("FAIL fill_read[%0d] got %h exp %h", i, rd_data, 16'h0010 + 16'(i));
            end
        end
        rd_addr = '0;
        tick();
        checks++; if (rd_data !== 16'h0015) begin errors++; $display("FAIL read_hold got %h exp 0015", rd_data); end
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL release_ready got %b exp 0", ready); end
        rd(0);
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL read_not_ready got %h exp 0000", rd_data); end
    endtask

    task automatic test_abort_reload();
        load(3, 16'h00A0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b exp 1", busy); end
        en = 1'b0; ld_vld = 1'b1; din = 16'h00EE;
        tick();
        ld_vld = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b exp 0", ovf); end
        en = 1'b1;
        load(6, 16'h0020);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reload_ready got %b exp 1", ready); end
        for (int i = 0; i < 6; i++) begin
            rd(i);
            checks++;
            if (rd_data !== 16'h0020 + 16'(i)) begin
                errors++; $display("FAIL reload_read[%0d] got %h exp %h", i, rd_data, 16'h0020 + 16'(i));
            end
        end
        rd(6);
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL read_addr_eq_n got %h exp 0000", rd_data); end
        rd(1);
        rd(63);
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL read_addr_63 got %h exp 0000", rd_data); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reload_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_reset_midway();
        rd(1);
        checks++; if (rd_data !== 16'h0021) begin errors++; $display("FAIL pre_reset_read got %h exp 0021", rd_data); end
        load(2, 16'h0050);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL midrst_rd_data got %h exp 0000", rd_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", ovf); end
        #2;
        rst_n = 1'b1;
        tick();
        load(6, 16'h0010);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL postrst_ready got %b exp 1", ready); end
        rd(0);
        checks++; if (rd_data !== 16'h0010) begin errors++; $display("FAIL postrst_read0 got %h exp 0010", rd_data); end
        rd(3);
        checks++; if (rd_data !== 16'h0013) begin errors++; $display("FAIL postrst_read3 got %h exp 0013", rd_data); end
    endtask

`ifdef IFMAP_SPAD_RX_DBUF_EN
    task automatic test_back_to_back();
        do_reset();
        load(12, 16'h0030);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf_pre got %b exp 0", ovf); end
        load(1, 16'h003C);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b exp 1", ovf); end
        rd(0);
        checks++; if (rd_data !== 16'h0030) begin errors++; $display("FAIL bank0_read0 got %h exp 0030", rd_data); end
        rd(5);
        checks++; if (rd_data !== 16'h0035) begin errors++; $display("FAIL bank0_read5 got %h exp 0035", rd_data); end
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL swap_ready got %b exp 1", ready); end
        rd(0);
        checks++; if (rd_data !== 16'h0036) begin errors++; $display("FAIL bank1_read0 got %h exp 0036", rd_data); end
        rd(5);
        checks++; if (rd_data !== 16'h003B) begin errors++; $display("FAIL bank1_read5 got %h exp 003b", rd_data); end
        load(6, 16'h0040);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL swap2_ready got %b exp 1", ready); end
        rd(2);
        checks++; if (rd_data !== 16'h0042) begin errors++; $display("FAIL swap2_read2 got %h exp 0042", rd_data); end
    endtask
`else
    task automatic test_overflow();
        do_reset();
        load(7, 16'h0030);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sb_ovf got %b exp 1", ovf); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sb_ready got %b exp 1", ready); end
        rd(0);
        checks++; if (rd_data !== 16'h0030) begin errors++; $display("FAIL sb_read0 got %h exp 0030", rd_data); end
        rd(5);
        checks++; if (rd_data !== 16'h0035) begin errors++; $display("FAIL sb_read5 got %h exp 0035", rd_data); end
    endtask
`endif

    task automatic test_cfg_err();
        do_reset();
        q = 5'd8; S = 5'd9;
        #1;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_72 got %b exp 1", cfg_err); end
        load(10, 16'h0060);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL cfg_ready got %b exp 0", ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL cfg_ovf got %b exp 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy got %b exp 0", busy); end
        q = 5'd0; S = 5'd3;
        #1;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_zero got %b exp 1", cfg_err); end
        q = 5'd8; S = 5'd8;
        #1;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_64 got %b exp 0", cfg_err); end
        load(64, 16'h0100);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full64_ready got %b exp 1", ready); end
        rd(63);
        checks++; if (rd_data !== 16'h013F) begin errors++; $display("FAIL full64_read63 got %h exp 013f", rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_abort_reload();
        test_reset_midway();
`ifdef IFMAP_SPAD_RX_DBUF_EN
        test_back_to_back();
`else
        test_overflow();
`endif
        test_cfg_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
